// File: rtl/lpc_host.sv
// -----------------------------------------------------------------------------
// lpc_host
//
// LPC bus host. It takes one IO or memory request at a time. For each request
// it runs the LPC frame START, CTDIR, SIZE, ADDR, WDATA, TAR and SYNC, then
// RDATA if the request is a read, then PTAR. It reports the result as a
// one-cycle response pulse. A SYNC phase that stalls for too long is ended
// with an LFRAME# abort sequence, and the response then carries status 2.
//
// Handshakes:
//   - Request side: valid/ready. A request is accepted on a rising edge where
//     req_valid && req_ready. All req_* inputs are captured on that edge.
//   - Response side: push-only. rsp_valid is high for exactly one cycle and
//     has no back-pressure.
//
// Ports:
//   lpc_clock, lpc_reset  clock (rising edge) and async active-high reset
//   req_valid/req_ready   request handshake
//   req_cyctype_dir       [3:2] 00 IO, 01 mem; [1] write; [0] 0
//   req_addr, req_data    address (IO uses [15:0]) and write data (byte 0 low)
//   req_size              0 = 1 byte, 1 = 2 bytes, 2/3 = 4 bytes (mem only)
//   rsp_valid/rsp_data/rsp_status   completion pulse, read data, status
//                                   (0 ok, 1 error sync, 2 aborted)
//   lpc_frame             LFRAME#, active low
//   lpc_ad_out/lpc_ad_oe  LAD drive value and output enable
//   lpc_ad_in             sampled LAD
// -----------------------------------------------------------------------------
module lpc_host #(
    parameter int SYNC_TIMEOUT = 8,
    parameter int SYNC_LIMIT   = 256
) (
    input  logic        lpc_clock,
    input  logic        lpc_reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_cyctype_dir,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [1:0]  req_size,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_status,
    output logic        lpc_frame,
    output logic [3:0]  lpc_ad_out,
    output logic        lpc_ad_oe,
    input  logic [3:0]  lpc_ad_in
);

    localparam int TW = $clog2(SYNC_TIMEOUT + 1);
    localparam int LW = $clog2(SYNC_LIMIT + 1);

    localparam logic [3:0] SYNC_READY = 4'b0000;
    localparam logic [3:0] SYNC_LWAIT = 4'b0110;
    localparam logic [3:0] SYNC_ERROR = 4'b1010;

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_CTDIR, S_SIZE, S_ADDR, S_WDATA, S_TAR1, S_TAR2,
        S_SYNC, S_RDATA, S_PTAR1, S_PTAR2, S_ABORT, S_RECOVER
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    nib_q, nib_d;       // nibble index, reused as the ABORT cycle count
    logic [TW-1:0] to_q, to_d;         // consecutive non-ready, non-long-wait SYNCs
    logic [LW-1:0] tot_q, tot_d;       // total SYNC cycles in this transfer
    logic [3:0]    ctdir_q, ctdir_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [1:0]    size_q, size_d;     // normalised: IO -> 0, 2 -> 3
    logic          err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_data_q, rsp_data_d;
    logic [1:0]    rsp_status_q, rsp_status_d;
    logic          frame_q, frame_d;
    logic [3:0]    ad_q, ad_d;
    logic          oe_q, oe_d;

    logic          is_mem, is_wr;
    logic [2:0]    addr_last, data_last, addr_sel;
    logic [TW-1:0] to_inc;
    logic [LW-1:0] tot_inc;

    assign is_mem    = (ctdir_q[3:2] == 2'b01);
    assign is_wr     = ctdir_q[1];
    assign addr_last = is_mem ? 3'd7 : 3'd3;
    assign data_last = (size_q == 2'd0) ? 3'd1 : (size_q == 2'd1) ? 3'd3 : 3'd7;
    assign to_inc    = to_q + TW'(1);
    assign tot_inc   = tot_q + LW'(1);

    // Ready is withheld in the response cycle, so the next request is taken
    // at the earliest in the cycle after rsp_valid.
    assign req_ready  = (state_q == S_IDLE) && !rsp_valid_q && !lpc_reset;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_status = rsp_status_q;
    assign lpc_frame  = frame_q;
    assign lpc_ad_out = ad_q;
    assign lpc_ad_oe  = oe_q;

    always_comb begin
        state_d      = state_q;
        nib_d        = nib_q;
        to_d         = to_q;
        tot_d        = tot_q;
        ctdir_d      = ctdir_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        err_d        = err_q;
        rdata_d      = rdata_q;
        rsp_valid_d  = 1'b0;
        rsp_data_d   = rsp_data_q;
        rsp_status_d = rsp_status_q;
        addr_sel     = 3'd0;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    ctdir_d = req_cyctype_dir;
                    addr_d  = req_addr;
                    wdata_d = req_data;
                    if (req_cyctype_dir[3:2] != 2'b01) size_d = 2'd0;
                    else if (req_size == 2'd2)         size_d = 2'd3;
                    else                               size_d = req_size;
                    err_d   = 1'b0;
                    rdata_d = 32'h0;
                    nib_d   = 3'd0;
                    to_d    = '0;
                    tot_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: state_d = S_CTDIR;
            S_CTDIR: begin
                nib_d   = 3'd0;
                state_d = is_mem ? S_SIZE : S_ADDR;
            end
            S_SIZE: begin
                nib_d   = 3'd0;
                state_d = S_ADDR;
            end
            S_ADDR: begin
                if (nib_q == addr_last) begin
                    nib_d   = 3'd0;
                    state_d = is_wr ? S_WDATA : S_TAR1;
                end else begin
                    nib_d = nib_q + 3'd1;
                end
            end
            S_WDATA: begin
                if (nib_q == data_last) begin
                    nib_d   = 3'd0;
                    state_d = S_TAR1;
                end else begin
                    nib_d = nib_q + 3'd1;
                end
            end
            S_TAR1: state_d = S_TAR2;
            S_TAR2: begin
                to_d    = '0;
                tot_d   = '0;
                state_d = S_SYNC;
            end
            S_SYNC: begin
                tot_d = tot_inc;
                if (lpc_ad_in == SYNC_READY || lpc_ad_in == SYNC_ERROR) begin
                    // An error sync finishes the cycle like ready; only the status differs.
                    if (lpc_ad_in == SYNC_ERROR) err_d = 1'b1;
                    nib_d   = 3'd0;
                    state_d = is_wr ? S_PTAR1 : S_RDATA;
                end else begin
                    if (lpc_ad_in == SYNC_LWAIT) to_d = '0;
                    else                         to_d = to_inc;
                    if ((lpc_ad_in != SYNC_LWAIT && to_inc == TW'(SYNC_TIMEOUT)) ||
                        tot_inc == LW'(SYNC_LIMIT)) begin
                        nib_d   = 3'd0;
                        state_d = S_ABORT;
                    end
                end
            end
            S_RDATA: begin
                rdata_d[{nib_q, 2'b00} +: 4] = lpc_ad_in;
                if (nib_q == data_last) begin
                    nib_d   = 3'd0;
                    state_d = S_PTAR1;
                end else begin
                    nib_d = nib_q + 3'd1;
                end
            end
            S_PTAR1: state_d = S_PTAR2;
            S_PTAR2: begin
                rsp_valid_d  = 1'b1;
                rsp_data_d   = is_wr ? 32'h0 : rdata_q;
                rsp_status_d = err_q ? 2'd1 : 2'd0;
                state_d      = S_IDLE;
            end
            S_ABORT: begin
                if (nib_q == 3'd3) begin
                    nib_d   = 3'd0;
                    state_d = S_RECOVER;
                end else begin
                    nib_d = nib_q + 3'd1;
                end
            end
            S_RECOVER: begin
                rsp_valid_d  = 1'b1;
                rsp_data_d   = 32'h0;
                rsp_status_d = 2'd2;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Bus pins are registered, so they are decoded from the state being entered.
        frame_d = 1'b1;
        oe_d    = 1'b0;
        ad_d    = 4'hF;
        unique case (state_d)
            S_START: begin
                frame_d = 1'b0;
                oe_d    = 1'b1;
                ad_d    = 4'h0;
            end
            S_CTDIR: begin
                oe_d = 1'b1;
                ad_d = ctdir_q;
            end
            S_SIZE: begin
                oe_d = 1'b1;
                ad_d = {2'b00, size_q};
            end
            S_ADDR: begin
                // Most significant nibble first: index 7-n for mem, 3-n for IO.
                addr_sel = is_mem ? ~nib_d : {1'b0, ~nib_d[1:0]};
                oe_d     = 1'b1;
                ad_d     = addr_q[{addr_sel, 2'b00} +: 4];
            end
            S_WDATA: begin
                oe_d = 1'b1;
                ad_d = wdata_q[{nib_d, 2'b00} +: 4];
            end
            S_TAR1: oe_d = 1'b1;
            S_ABORT: begin
                frame_d = 1'b0;
                oe_d    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge lpc_clock or posedge lpc_reset) begin
        if (lpc_reset) begin
            state_q      <= S_IDLE;
            nib_q        <= 3'd0;
            to_q         <= '0;
            tot_q        <= '0;
            ctdir_q      <= 4'h0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            size_q       <= 2'd0;
            err_q        <= 1'b0;
            rdata_q      <= 32'h0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= 32'h0;
            rsp_status_q <= 2'd0;
            frame_q      <= 1'b1;
            ad_q         <= 4'hF;
            oe_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            nib_q        <= nib_d;
            to_q         <= to_d;
            tot_q        <= tot_d;
            ctdir_q      <= ctdir_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            size_q       <= size_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
            frame_q      <= frame_d;
            ad_q         <= ad_d;
            oe_q         <= oe_d;
        end
    end

endmodule

// File: tb/tb_lpc_host.sv
// -----------------------------------------------------------------------------
// tb_lpc_host
//
// Directed bench for lpc_host.
// - The main initial block drives requests.
// - A peripheral/monitor block answers SYNC and RDATA from a nibble queue.
// - The monitor block logs every driven LAD nibble.
// - Completions are scored against an expected-response queue.
// -----------------------------------------------------------------------------
module tb_lpc_host;

    logic        lpc_clock = 1'b0;
    logic        lpc_reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_cyctype_dir = 4'h0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_data = 32'h0;
    logic [1:0]  req_size = 2'd0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_status;
    logic        lpc_frame;
    logic [3:0]  lpc_ad_out;
    logic        lpc_ad_oe;
    logic [3:0]  lpc_ad_in = 4'hF;

    lpc_host dut (
        .lpc_clock       (lpc_clock),
        .lpc_reset       (lpc_reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_cyctype_dir (req_cyctype_dir),
        .req_addr        (req_addr),
        .req_data        (req_data),
        .req_size        (req_size),
        .rsp_valid       (rsp_valid),
        .rsp_data        (rsp_data),
        .rsp_status      (rsp_status),
        .lpc_frame       (lpc_frame),
        .lpc_ad_out      (lpc_ad_out),
        .lpc_ad_oe       (lpc_ad_oe),
        .lpc_ad_in       (lpc_ad_in)
    );

    // ---------------- clock / reset ----------------
    always #5 lpc_clock = ~lpc_clock;

    int cyc = 0;
    always @(posedge lpc_clock) cyc <= cyc + 1;

    // ---------------- bookkeeping ----------------
    int          n_cmp = 0;
    int          n_err = 0;
    int          rsp_cnt = 0;
    int          rsp_cyc = 0;
    int          hs_cyc = 0;
    logic [33:0] exp_q[$];     // {status, data}
    logic [3:0]  per_q[$];     // peripheral SYNC/RDATA nibbles
    logic [4:0]  bus_q[$];     // {frame, ad} for every cycle with oe=1
    logic [4:0]  exp_bus[$];
    logic        sync_go = 1'b0;
    logic        prev_tar1 = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_bus(input string tag);
        check({tag, "_len"}, 64'(bus_q.size()), 64'(exp_bus.size()));
        for (int i = 0; i < exp_bus.size() && i < bus_q.size(); i++)
            check($sformatf("%s_%0d", tag, i), 64'(bus_q[i]), 64'(exp_bus[i]));
    endtask

    // ---------------- peripheral model + monitor + scoreboard ----------------
    always begin
        @(posedge lpc_clock);
        #1;
        if (lpc_reset) begin
            sync_go   = 1'b0;
            prev_tar1 = 1'b0;
        end else begin
            if (sync_go) begin
                if (per_q.size() > 0) lpc_ad_in = per_q.pop_front();
                else                  lpc_ad_in = 4'hF;
            end
            // TAR2: oe just dropped after the host drove 1111 with LFRAME# high.
            if (prev_tar1 && !lpc_ad_oe && lpc_frame) sync_go = 1'b1;
            prev_tar1 = lpc_ad_oe && lpc_frame && (lpc_ad_out == 4'hF);
            if (lpc_ad_oe) bus_q.push_back({lpc_frame, lpc_ad_out});
            else           check("ad_out_when_oe_low", 64'(lpc_ad_out), 64'hF);
            if (rsp_valid) begin
                check("ready_low_in_rsp_cycle", 64'(req_ready), 64'h0);
                check("rsp_pending", 64'(exp_q.size() != 0), 64'h1);
                if (exp_q.size() != 0)
                    check("rsp_status_data", 64'({rsp_status, rsp_data}), 64'(exp_q.pop_front()));
                rsp_cnt++;
                rsp_cyc   = cyc;
                sync_go   = 1'b0;
                per_q.delete();
                lpc_ad_in = 4'hF;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [3:0] ct, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz, input logic push_exp, input logic [33:0] ex);
        int n;
        n = 0;
        req_cyctype_dir = ct;
        req_addr        = a;
        req_data        = d;
        req_size        = sz;
        req_valid       = 1'b1;
        if (push_exp) exp_q.push_back(ex);
        while (!req_ready && n < 300) begin
            @(posedge lpc_clock);
            #2;
            n++;
        end
        check("req_accepted", 64'(req_ready), 64'h1);
        @(posedge lpc_clock);
        #2;
        hs_cyc    = cyc;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int budget);
        int start;
        int n;
        start = rsp_cnt;
        n     = 0;
        while (rsp_cnt == start && n < budget) begin
            @(posedge lpc_clock);
            #2;
            n++;
        end
        check("rsp_seen", 64'(rsp_cnt), 64'(start + 1));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int r0;

        // Reset values
        repeat (3) @(posedge lpc_clock);
        #2;
        check("rst_frame", 64'(lpc_frame), 64'h1);
        check("rst_oe", 64'(lpc_ad_oe), 64'h0);
        check("rst_ad", 64'(lpc_ad_out), 64'hF);
        check("rst_ready", 64'(req_ready), 64'h0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        check("rst_rsp_data", 64'(rsp_data), 64'h0);
        check("rst_rsp_status", 64'(rsp_status), 64'h0);
        lpc_reset = 1'b0;
        @(posedge lpc_clock);
        #2;
        check("ready_after_reset", 64'(req_ready), 64'h1);

        // Mem read, 2 bytes, four long waits then ready
        bus_q.delete();
        per_q   = '{4'h6, 4'h6, 4'h6, 4'h6, 4'h0, 4'hc, 4'h6, 4'hf, 4'hd};
        exp_bus = '{5'h00, 5'h14, 5'h11, 5'h1a, 5'h1f, 5'h1f, 5'h1e, 5'h17, 5'h1f, 5'h1e, 5'h15, 5'h1f};
        send(4'b0100, 32'haffe7fe5, 32'h0, 2'd1, 1'b1, {2'd0, 32'h0000df6c});
        wait_rsp(100);
        check_bus("memrd2_bus");

        // IO write, 1 byte, immediate ready: 13-cycle latency
        bus_q.delete();
        per_q   = '{4'h0};
        exp_bus = '{5'h00, 5'h12, 5'h10, 5'h10, 5'h18, 5'h10, 5'h1a, 5'h15, 5'h1f};
        send(4'b0010, 32'h00000080, 32'h0000005a, 2'd0, 1'b1, {2'd0, 32'h0});
        wait_rsp(100);
        check("iowr_latency", 64'(rsp_cyc - hs_cyc), 64'd13);
        check_bus("iowr_bus");

        // Mem read, 1 byte, error sync: 18-cycle latency, status 1
        bus_q.delete();
        per_q   = '{4'ha, 4'h3, 4'hc};
        exp_bus = '{5'h00, 5'h14, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h11, 5'h10, 5'h1f};
        send(4'b0100, 32'h00000010, 32'h0, 2'd0, 1'b1, {2'd1, 32'h000000c3});
        wait_rsp(100);
        check("memrd1_latency", 64'(rsp_cyc - hs_cyc), 64'd18);
        check_bus("memrd1_bus");

        // Mem read, 4 bytes, short waits only: abort after the 8th
        bus_q.delete();
        per_q.delete();
        for (int i = 0; i < 9; i++) per_q.push_back(4'h5);
        exp_bus = '{5'h00, 5'h14, 5'h13, 5'h11, 5'h12, 5'h13, 5'h14, 5'h15, 5'h16, 5'h17, 5'h18,
                    5'h1f, 5'h0f, 5'h0f, 5'h0f, 5'h0f};
        send(4'b0100, 32'h12345678, 32'h0, 2'd3, 1'b1, {2'd2, 32'h0});
        wait_rsp(100);
        check("abort_latency", 64'(rsp_cyc - hs_cyc), 64'd26);
        check_bus("abort_bus");

        // Mem write, size code 2 treated as 4 bytes, long waits then ready
        bus_q.delete();
        per_q   = '{4'h6, 4'h6, 4'h0};
        exp_bus = '{5'h00, 5'h16, 5'h13, 5'h10, 5'h10, 5'h10, 5'h10, 5'h1f, 5'h10, 5'h10, 5'h1d,
                    5'h1b, 5'h1b, 5'h1a, 5'h1a, 5'h19, 5'h19, 5'h18, 5'h18, 5'h1f};
        send(4'b0110, 32'h0000f00d, 32'h8899aabb, 2'd2, 1'b1, {2'd0, 32'h0});
        wait_rsp(100);
        check_bus("memwr4_bus");

        // 7 short waits, a long wait clears the count, 7 more, then ready
        per_q.delete();
        for (int i = 0; i < 7; i++) per_q.push_back(4'h5);
        per_q.push_back(4'h6);
        for (int i = 0; i < 7; i++) per_q.push_back(4'h5);
        per_q.push_back(4'h0);
        per_q.push_back(4'h1);
        per_q.push_back(4'h2);
        send(4'b0100, 32'h0, 32'h0, 2'd0, 1'b1, {2'd0, 32'h00000021});
        wait_rsp(100);

        // Back-to-back: request held from the response cycle on
        r0 = rsp_cyc;
        per_q = '{4'h0};
        send(4'b0010, 32'h000000ff, 32'h0000003c, 2'd0, 1'b1, {2'd0, 32'h0});
        check("b2b_accept_gap", 64'(hs_cyc - r0), 64'd2);
        wait_rsp(100);

        // Long waits forever: total SYNC limit reached at 256
        per_q.delete();
        for (int i = 0; i < 300; i++) per_q.push_back(4'h6);
        send(4'b0100, 32'h0, 32'h0, 2'd0, 1'b1, {2'd2, 32'h0});
        wait_rsp(400);
        check("limit_latency", 64'(rsp_cyc - hs_cyc), 64'd274);

        // Reset during ADDR: bus released at once, no response
        r0 = rsp_cnt;
        send(4'b0000, 32'h00001234, 32'h0, 2'd0, 1'b0, 34'h0);
        @(posedge lpc_clock);
        @(posedge lpc_clock);
        #3;
        check("pre_reset_oe_in_addr", 64'(lpc_ad_oe), 64'h1);
        lpc_reset = 1'b1;
        #1;
        check("midrst_frame", 64'(lpc_frame), 64'h1);
        check("midrst_oe", 64'(lpc_ad_oe), 64'h0);
        check("midrst_ad", 64'(lpc_ad_out), 64'hF);
        check("midrst_ready", 64'(req_ready), 64'h0);
        repeat (3) @(posedge lpc_clock);
        #2;
        check("midrst_rsp_valid", 64'(rsp_valid), 64'h0);
        lpc_reset = 1'b0;
        @(posedge lpc_clock);
        #2;
        check("post_rst_ready", 64'(req_ready), 64'h1);
        check("post_rst_no_rsp", 64'(rsp_cnt), 64'(r0));

        // IO read after reset: upper address and size ignored
        bus_q.delete();
        per_q   = '{4'h0, 4'h7, 4'he};
        exp_bus = '{5'h00, 5'h10, 5'h11, 5'h12, 5'h13, 5'h14, 5'h1f};
        send(4'b0000, 32'hdead1234, 32'h0, 2'd3, 1'b1, {2'd0, 32'h000000e7});
        wait_rsp(100);
        check_bus("iord_bus");
        check("exp_q_drained", 64'(exp_q.size()), 64'h0);

        repeat (3) @(posedge lpc_clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
